pipeline_hazard_controller: RTL
===============================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter FORWARD_EN, default 0: 1 = forwarding present, stall only on load-use; 0 = stall on any RAW.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15: maximum wait cycles for a memory access before error.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port id_valid  in  1  ID holds a real instruction.
REQ-006 SHALL have port id_src1  in  5  first source register.
REQ-007 SHALL have port id_src2  in  5  second source register.
REQ-008 SHALL have port id_two_src  in  1  src2 is read (0 for immediate forms except ST/BNE).
REQ-009 SHALL have port id_dest  in  5  destination register.
REQ-010 SHALL have port id_wb_en  in  1  ID instruction writes back (control-unit wb_en).
REQ-011 SHALL have port id_mem_read  in  1  ID instruction is a load.
REQ-012 SHALL have port id_mem_access  in  1  ID instruction is a load or store.
REQ-013 SHALL have port branch_taken  in  1  branch resolved taken in EXE.
REQ-014 SHALL have port mem_ready  in  1  memory completed the current MEM-stage access.
REQ-015 SHALL have port hazard_stall  out  1  hold PC and IF/ID; insert bubble into ID/EXE.
REQ-016 SHALL have port flush  out  1  kill IF/ID contents and insert bubble into ID/EXE.
REQ-017 SHALL have port freeze  out  1  hold every pipeline register.
REQ-018 SHALL have port mem_timeout  out  1  sticky memory-timeout error.
REQ-019 SHALL have port stall_count  out  16  saturating count of cycles with hazard_stall or freeze.

Function
REQ-020 SHALL keep a two-entry scoreboard (EXE, MEM) of {valid, dest, wb_en, mem_read, mem_access}; each non-frozen cycle EXE<=ID entry (or bubble) and MEM<=EXE.
REQ-021 SHALL load a bubble (all fields 0) into the EXE entry when hazard_stall, flush or !id_valid.
REQ-022 SHALL treat register 0 as never hazardous; unused src2 (id_two_src=0) SHALL never match.
REQ-023 With FORWARD_EN=0, SHALL assert hazard_stall combinationally when id_valid and a used source equals the dest of a valid wb_en entry in EXE or MEM.
REQ-024 With FORWARD_EN=1, SHALL assert hazard_stall only when a used source equals the EXE entry dest and that entry has mem_read=1.
REQ-025 SHALL assert flush combinationally in any cycle with branch_taken=1 and freeze=0.
REQ-026 SHALL run memory FSM IDLE/WAIT/ERR: IDLE->WAIT when the MEM entry has mem_access and mem_ready=0; WAIT->IDLE on mem_ready; WAIT->ERR when wait counter reaches MEM_TIMEOUT; ERR held until reset.
REQ-027 SHALL assert freeze combinationally whenever the MEM entry has mem_access and mem_ready=0, and in ERR; mem_ready=1 in the access cycle SHALL produce no freeze (zero-wait).
REQ-028 SHALL clear the wait counter on entering WAIT; counter width ceil(log2(MEM_TIMEOUT+1)).
REQ-029 SHALL assert mem_timeout from the cycle after entry to ERR until reset.
REQ-030 Priority SHALL be freeze > flush > hazard_stall: when freeze=1, flush and hazard_stall SHALL be 0 and the scoreboard SHALL hold; when flush=1, hazard_stall SHALL be 0.
REQ-031 stall_count SHALL increment by 1 in each cycle with hazard_stall or freeze, and saturate at 16'hFFFF.

Reset
REQ-032 On rst=1 at a clock edge: scoreboard entries bubbled, FSM IDLE, wait counter 0, mem_timeout 0, stall_count 0.
REQ-033 hazard_stall, flush and freeze SHALL be 0 while rst=1; reset mid-WAIT SHALL abandon the access without error.

Structure
REQ-034 The scoreboard entry struct, FSM state encoding and the register-0 constant SHALL live in a shared package pipeline_pkg.
REQ-035 The memory wait FSM plus counter SHALL be one sub-module mem_wait_fsm; the rest is flat.

Verification
REQ-036 FORWARD_EN=0: ADD r3 in EXE, ID reads r3 -> hazard_stall=1 for 2 cycles, then 0; EXE entry bubbled each stall cycle.
REQ-037 FORWARD_EN=1: LD r5 in EXE, ID reads r5 -> exactly 1 stall cycle; ADD r5 in EXE -> no stall.
REQ-038 ID src1=0 with EXE dest=0, wb_en=1 -> hazard_stall=0.
REQ-039 LD in MEM, mem_ready low 3 cycles -> freeze=1 exactly 3 cycles, stall_count +3; branch_taken during freeze -> flush=0 until freeze drops.
REQ-040 MEM_TIMEOUT=4, mem_ready held low -> ERR entered on the wait counter reaching 4, mem_timeout=1 the following cycle and sticky; rst clears it and freeze.
REQ-041 branch_taken and RAW hazard in the same cycle -> flush=1, hazard_stall=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   sb_entry_t  : one in-flight instruction as seen by the hazard logic
//   SB_BUBBLE   : the empty scoreboard entry (all fields zero)
//   mem_state_t : memory-wait FSM encoding
//   REG_ZERO    : hard-wired zero register, never a dependency
//   src_hits()  : does a (used) source register name a given destination
package pipeline_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_read;
        logic             mem_access;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } mem_state_t;

    // r0 always reads as zero, so it can never carry a dependency.
    function automatic logic src_hits(input logic [REG_W-1:0] src,
                                      input logic             used,
                                      input logic [REG_W-1:0] dest);
        return used && (src != REG_ZERO) && (src == dest);
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Memory-wait tracker for the MEM stage.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   mem_access   : MEM-stage entry is a load or store
//   mem_ready    : memory finished the current access this cycle
//   freeze       : hold every pipeline register (access pending or error)
//   mem_timeout  : sticky error, set the cycle after ERR is entered
module mem_wait_fsm
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_access,
    input  logic mem_ready,
    output logic freeze,
    output logic mem_timeout
);

    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    mem_state_t       state, state_next;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic             access_pending;

    // A ready access completes in its own cycle and never freezes.
    assign access_pending = mem_access && !mem_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MEM_IDLE;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            mem_timeout <= (state == MEM_ERR);
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            MEM_IDLE: begin
                if (access_pending) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next = MEM_IDLE;
                end else if (wait_cnt == CNT_LIMIT) begin
                    state_next = MEM_ERR;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            MEM_ERR: begin
                state_next = MEM_ERR;
            end
            default: begin
                state_next = MEM_IDLE;
            end
        endcase
    end

    assign freeze = !rst && (access_pending || (state == MEM_ERR));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for a 5-stage in-order pipeline.
// Tracks the instructions in EXE and MEM and produces:
//   hazard_stall : RAW dependency of the ID instruction (hold PC, IF/ID)
//   flush        : taken branch, kill IF/ID and bubble ID/EXE
//   freeze       : MEM access outstanding or memory error, hold everything
//   mem_timeout  : sticky memory-timeout error
//   stall_count  : saturating count of cycles with hazard_stall or freeze
// Parameters: FORWARD_EN (1 = only load-use stalls), MEM_TIMEOUT (wait limit).
// Priority is freeze > flush > hazard_stall; rst forces all three low.
module pipeline_hazard_controller
    import pipeline_pkg::*;
#(
    parameter bit FORWARD_EN  = 1'b0,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_src1,
    input  logic [4:0]  id_src2,
    input  logic        id_two_src,
    input  logic [4:0]  id_dest,
    input  logic        id_wb_en,
    input  logic        id_mem_read,
    input  logic        id_mem_access,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        hazard_stall,
    output logic        flush,
    output logic        freeze,
    output logic        mem_timeout,
    output logic [15:0] stall_count
);

    sb_entry_t id_entry, exe_entry, mem_entry;
    logic      reads_exe, reads_mem, raw_hazard;

    assign id_entry = '{valid:      1'b1,
                        dest:       id_dest,
                        wb_en:      id_wb_en,
                        mem_read:   id_mem_read,
                        mem_access: id_mem_access};

    assign reads_exe = src_hits(id_src1, 1'b1, exe_entry.dest)
                     | src_hits(id_src2, id_two_src, exe_entry.dest);
    assign reads_mem = src_hits(id_src1, 1'b1, mem_entry.dest)
                     | src_hits(id_src2, id_two_src, mem_entry.dest);

    always_comb begin
        raw_hazard = 1'b0;
        if (FORWARD_EN) begin
            // Forwarding covers everything except a load result still in EXE.
            raw_hazard = id_valid && exe_entry.valid && exe_entry.mem_read && reads_exe;
        end else begin
            raw_hazard = id_valid &&
                         ((exe_entry.valid && exe_entry.wb_en && reads_exe) ||
                          (mem_entry.valid && mem_entry.wb_en && reads_mem));
        end
    end

    // A load is always a memory access, even if the decoder flags only mem_read.
    mem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_fsm (
        .clk         (clk),
        .rst         (rst),
        .mem_access  (mem_entry.mem_access | mem_entry.mem_read),
        .mem_ready   (mem_ready),
        .freeze      (freeze),
        .mem_timeout (mem_timeout)
    );

    assign flush        = !rst && !freeze && branch_taken;
    assign hazard_stall = !rst && !freeze && !flush && raw_hazard;

    // NOTE: the two scoreboard entries are reset explicitly: a stale valid bit
    // would raise phantom hazards or a phantom memory access after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_entry <= SB_BUBBLE;
            mem_entry <= SB_BUBBLE;
        end else if (!freeze) begin
            exe_entry <= (hazard_stall || flush || !id_valid) ? SB_BUBBLE : id_entry;
            mem_entry <= exe_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if ((hazard_stall || freeze) && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule
